// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of the FIFO controller's stream, status and RAM-side signals.
//   slave  : seen from the controller (drives wr_ready, rd_*, status and RAM port A/B controls)
//   master : seen from the environment (drives wr_*, rd_ready, flush, ram_outb)
// Signals:
//   flush                      synchronous clear of FIFO state
//   wr_valid/wr_ready/wr_data  input stream
//   rd_valid/rd_ready/rd_data  output stream (rd_data is the RAM's registered port-B output)
//   count/full/empty/ovf       occupancy status, ovf sticky until reset
//   ram_*                      RAM port A (write) and port B (read) controls and data
interface ram_fifo_ctrl_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
);
   logic              flush;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              ovf;
   logic              ram_ena;
   logic              ram_wea;
   logic [ADDR_W-1:0] ram_ada;
   logic [DATA_W-1:0] ram_ina;
   logic              ram_enb;
   logic              ram_web;
   logic [ADDR_W-1:0] ram_adb;
   logic [DATA_W-1:0] ram_outb;

   modport slave (
      input  flush, wr_valid, wr_data, rd_ready, ram_outb,
      output wr_ready, rd_valid, rd_data, count, full, empty, ovf,
             ram_ena, ram_wea, ram_ada, ram_ina, ram_enb, ram_web, ram_adb
   );

   modport master (
      output flush, wr_valid, wr_data, rd_ready, ram_outb,
      input  wr_ready, rd_valid, rd_data, count, full, empty, ovf,
             ram_ena, ram_wea, ram_ada, ram_ina, ram_enb, ram_web, ram_adb
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM.
// Port A of the RAM is the write port, port B the read port; the RAM's registered port-B output
// is the output data register, so a read issued in cycle t presents its word in cycle t+1.
// Ports:
//   clk  single clock (RAM clka/clkb tied to it)
//   rst  synchronous active-high reset
//   bus  ram_fifo_ctrl_if.slave: stream in/out, status, RAM port controls
module ram_fifo_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
) (
   input logic             clk,
   input logic             rst,
   ram_fifo_ctrl_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [0:0] {StEmpty, StPresent} rd_state_e;

   rd_state_e         rd_state_q, rd_state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;

   logic              rd_valid;
   logic              full;
   logic              accept;
   logic              pop;
   logic              issue;
   logic [ADDR_W:0]   unread;

   assign rd_valid = (rd_state_q == StPresent);
   assign full     = (count_q == (ADDR_W+1)'(DEPTH));

   // The presented word stays counted until popped, which keeps its RAM slot out of reach of
   // the write pointer while it is held on ram_outb.
   assign unread = count_q - (ADDR_W+1)'(rd_valid);
   assign accept = bus.wr_valid & bus.wr_ready;
   assign pop    = rd_valid & bus.rd_ready;
   assign issue  = !rst && !bus.flush && (unread != '0) && (!rd_valid || bus.rd_ready);

   assign bus.wr_ready = !rst & !bus.flush & !full;
   assign bus.rd_valid = rd_valid;
   assign bus.rd_data  = bus.ram_outb;
   assign bus.count    = count_q;
   assign bus.full     = full;
   assign bus.empty    = (count_q == '0);
   assign bus.ovf      = ovf_q;

   assign bus.ram_ena = accept;
   assign bus.ram_wea = accept;
   assign bus.ram_ada = wptr_q;
   assign bus.ram_ina = bus.wr_data;
   assign bus.ram_enb = issue;
   assign bus.ram_web = 1'b0;
   assign bus.ram_adb = rptr_q;

   always_comb begin
      rd_state_d = rd_state_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q | (bus.wr_valid & full);
      if (rst) begin
         rd_state_d = StEmpty;
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
         ovf_d      = 1'b0;
      end else if (bus.flush) begin
         rd_state_d = StEmpty;
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
      end else begin
         wptr_d  = wptr_q + ADDR_W'(accept);
         rptr_d  = rptr_q + ADDR_W'(issue);
         count_d = count_q + (ADDR_W+1)'(accept) - (ADDR_W+1)'(pop);
         unique case (rd_state_q)
            StEmpty:   if (issue) rd_state_d = StPresent;
            StPresent: if (bus.rd_ready && !issue) rd_state_d = StEmpty;
            default:   rd_state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      rd_state_q <= rd_state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
   end
endmodule
